alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 81 ++++++++
 rtl/alu_issue_ctrl_reg_file.sv | 66 ++++++
 rtl/alu_issue_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// condition codes, status-flag bit positions and instruction field layout.
package alu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Status register bit positions, {N,Z,C,V}
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Instruction word field positions (LSB of each field)
    localparam int INSTR_COND_LSB = 28;
    localparam int INSTR_SR_LSB   = 25;
    localparam int INSTR_S_BIT    = 24;
    localparam int INSTR_OP_LSB   = 20;
    localparam int INSTR_RD_LSB   = 16;
    localparam int INSTR_RS1_LSB  = 12;
    localparam int INSTR_RS2_LSB  = 8;
    localparam int INSTR_IMM_LSB  = 0;

    // Highest encodings the ALU understands
    localparam logic [3:0] OP_CODE_MAX = 4'd5;
    localparam logic [2:0] SR_CTRL_MAX = 3'd3;

    // Condition evaluation against the {N,Z,C,V} status word
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flg);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = flg[FLG_N];
        z = flg[FLG_Z];
        c = flg[FLG_C];
        v = flg[FLG_V];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// 16-entry register file: two registered read ports (updated only when
// re is high, holding their value otherwise), one combinational debug
// port and a single write port. Synchronous reset clears every entry.
module reg_file_16x32 #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [DATA_W-1:0]       rd1,
    output logic [DATA_W-1:0]       rd2,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [DATA_W-1:0]       wd
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_q;
    logic [DATA_W-1:0] rd2_d;

    // Next array contents: single write port
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wa] = wd;
        end
    end

    // Read ports capture the array only when enabled so operands stay stable
    always_comb begin
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        if (re) begin
            rd1_d = mem_q[ra1];
            rd2_d = mem_q[ra2];
        end
    end

    // Storage and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign rd1      = rd1_q;
    assign rd2      = rd2_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external ALU: accepts one instruction at a time,
// reads operands, presents them with control fields to the ALU, and writes
// the result and optionally the status flags back under condition control.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new instruction; register preloads accepted here
// DECODE | read operands, latch ALU controls, evaluate condition/legality
// EXEC   | ALU settle cycle, controls and operands held
// WB     | sample ALU result, commit if legal and condition passed, done
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    input  logic [31:0]             instr,
    output logic                    instr_ready,
    input  logic                    load_en,
    input  logic [$clog2(NREG)-1:0] load_addr,
    input  logic [DATA_W-1:0]       load_data,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    output logic [DATA_W-1:0]       alu_R1,
    output logic [DATA_W-1:0]       alu_R2,
    output logic [3:0]              alu_op_code,
    output logic [2:0]              alu_SR_Control,
    output logic [3:0]              alu_Cond,
    output logic                    alu_S,
    output logic [15:0]             alu_Imm,
    output logic [3:0]              alu_flags,
    input  logic [DATA_W:0]         alu_out,
    input  logic [3:0]              alu_FLG,
    output logic [3:0]              flags,
    output logic                    done,
    output logic                    illegal
);

    localparam int AW = $clog2(NREG);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        legal_q, legal_d;
    logic        pass_q, pass_d;
    logic [3:0]  cond_q, cond_d;
    logic [2:0]  sr_q, sr_d;
    logic        s_q, s_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] imm_q, imm_d;
    logic [3:0]  flags_q, flags_d;

    logic            accept;
    logic            load_fire;
    logic            wb_commit;
    logic            rf_re;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [AW-1:0]   rs1_idx;
    logic [AW-1:0]   rs2_idx;
    logic [AW-1:0]   rd_idx;
    logic            alu_carry_unused;

    assign instr_ready = (state_q == ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign load_fire   = load_en && (state_q == ST_IDLE);
    assign rf_re       = (state_q == ST_DECODE);
    assign wb_commit   = (state_q == ST_WB) && legal_q && pass_q;

    assign rs1_idx = instr_q[INSTR_RS1_LSB +: AW];
    assign rs2_idx = instr_q[INSTR_RS2_LSB +: AW];
    assign rd_idx  = instr_q[INSTR_RD_LSB +: AW];

    // The ALU carry-out bit is reported through alu_FLG; the result keeps DATA_W bits
    assign alu_carry_unused = alu_out[DATA_W];

    // Write port is shared; load only happens in IDLE and write-back only in WB
    assign rf_we = load_fire || wb_commit;
    assign rf_wa = wb_commit ? rd_idx : load_addr;
    assign rf_wd = wb_commit ? alu_out[DATA_W-1:0] : load_data;

    // Next-state, instruction capture, decode-time latching and flag update
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        legal_d = legal_q;
        pass_d  = pass_q;
        cond_d  = cond_q;
        sr_d    = sr_q;
        s_d     = s_q;
        op_d    = op_q;
        imm_d   = imm_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cond_d  = instr_q[INSTR_COND_LSB +: 4];
                sr_d    = instr_q[INSTR_SR_LSB +: 3];
                s_d     = instr_q[INSTR_S_BIT];
                op_d    = instr_q[INSTR_OP_LSB +: 4];
                imm_d   = instr_q[INSTR_IMM_LSB +: 16];
                legal_d = (instr_q[INSTR_OP_LSB +: 4] <= OP_CODE_MAX) &&
                          (instr_q[INSTR_SR_LSB +: 3] <= SR_CTRL_MAX);
                pass_d  = cond_pass(instr_q[INSTR_COND_LSB +: 4], flags_q);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                if (wb_commit && s_q) begin
                    flags_d = alu_FLG;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state; reset aborts any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            legal_q <= 1'b0;
            pass_q  <= 1'b0;
            cond_q  <= '0;
            sr_q    <= '0;
            s_q     <= 1'b0;
            op_q    <= '0;
            imm_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            legal_q <= legal_d;
            pass_q  <= pass_d;
            cond_q  <= cond_d;
            sr_q    <= sr_d;
            s_q     <= s_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            flags_q <= flags_d;
        end
    end

    reg_file_16x32 #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .re       (rf_re),
        .ra1      (rs1_idx),
        .ra2      (rs2_idx),
        .rd1      (alu_R1),
        .rd2      (alu_R2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (rf_wa),
        .wd       (rf_wd)
    );

    assign alu_op_code    = op_q;
    assign alu_SR_Control = sr_q;
    assign alu_Cond       = cond_q;
    assign alu_S          = s_q;
    assign alu_Imm        = imm_q;
    assign alu_flags      = flags_q;
    assign flags          = flags_q;
    assign done           = (state_q == ST_WB);
    assign illegal        = (state_q == ST_WB) && !legal_q;

endmodule
